// File: rtl/load_tid_tracker_if.sv
// Load-unit / memory-response bundle for the outstanding-load tracker.
// Signal names keep the tracker's port names so both sides read the same.
interface load_tid_tracker_if #(
    parameter int XLEN        = 64,
    parameter int NR_ENTRIES  = 2,
    parameter int TID_WIDTH   = 2,
    parameter int SB_ID_WIDTH = 3
);
    localparam int OFF_W = $clog2(XLEN/8);
    localparam int CNT_W = $clog2(NR_ENTRIES+1);

    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [SB_ID_WIDTH-1:0] req_trans_id_i;
    logic [OFF_W-1:0]       req_offset_i;
    logic [1:0]             req_size_i;
    logic                   req_signed_i;
    logic [TID_WIDTH-1:0]   req_tid_o;
    logic                   rsp_valid_i;
    logic [TID_WIDTH-1:0]   rsp_tid_i;
    logic [XLEN-1:0]        rsp_data_i;
    logic                   flush_i;
    logic                   wb_valid_o;
    logic [SB_ID_WIDTH-1:0] wb_trans_id_o;
    logic [XLEN-1:0]        wb_data_o;
    logic                   rsp_err_o;
    logic                   busy_o;
    logic [CNT_W-1:0]       count_o;

    modport slave (
        input  req_valid_i, req_trans_id_i, req_offset_i, req_size_i, req_signed_i,
        input  rsp_valid_i, rsp_tid_i, rsp_data_i, flush_i,
        output req_ready_o, req_tid_o, wb_valid_o, wb_trans_id_o, wb_data_o,
        output rsp_err_o, busy_o, count_o
    );

    modport master (
        output req_valid_i, req_trans_id_i, req_offset_i, req_size_i, req_signed_i,
        output rsp_valid_i, rsp_tid_i, rsp_data_i, flush_i,
        input  req_ready_o, req_tid_o, wb_valid_o, wb_trans_id_o, wb_data_o,
        input  rsp_err_o, busy_o, count_o
    );
endinterface

// File: rtl/load_tid_tracker.sv
// Outstanding-load tracker: allocates a memory TID per load, matches out-of-order
// responses by TID and writes back aligned, extended data one cycle later.
module load_tid_tracker #(
    parameter int XLEN        = 64,
    parameter int NR_ENTRIES  = 2,
    parameter int TID_WIDTH   = 2,
    parameter int SB_ID_WIDTH = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    load_tid_tracker_if.slave  bus
);
    localparam int OFF_W = $clog2(XLEN/8);
    localparam int CNT_W = $clog2(NR_ENTRIES+1);

    if ((2**TID_WIDTH) < NR_ENTRIES) begin : g_tid_check
        $error("TID_WIDTH too small for NR_ENTRIES");
    end

    // Shift the addressed bytes down, then zero- or sign-fill above the access size.
    function automatic logic [XLEN-1:0] extend_load(
        input logic [XLEN-1:0]  raw,
        input logic [OFF_W-1:0] off,
        input logic [1:0]       size,
        input logic             sgn
    );
        logic [XLEN-1:0]    sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        logic [XLEN-1:0]    res;
        sh = raw >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        w  = sh[31:0];
        case (size)
            2'd0:    res = sgn ? XLEN'(b) : XLEN'(sh[7:0]);
            2'd1:    res = sgn ? XLEN'(h) : XLEN'(sh[15:0]);
            2'd2:    res = sgn ? XLEN'(w) : XLEN'(sh[31:0]);
            default: res = sh;
        endcase
        return res;
    endfunction

    logic [NR_ENTRIES-1:0]  valid_q, valid_d;
    logic [NR_ENTRIES-1:0]  killed_q, killed_d;
    logic [SB_ID_WIDTH-1:0] sb_id_q [NR_ENTRIES];
    logic [SB_ID_WIDTH-1:0] sb_id_d [NR_ENTRIES];
    logic [OFF_W-1:0]       off_q   [NR_ENTRIES];
    logic [OFF_W-1:0]       off_d   [NR_ENTRIES];
    logic [1:0]             size_q  [NR_ENTRIES];
    logic [1:0]             size_d  [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]  sgn_q, sgn_d;

    logic                   wb_valid_q, wb_valid_d;
    logic [SB_ID_WIDTH-1:0] wb_trans_id_q, wb_trans_id_d;
    logic [XLEN-1:0]        wb_data_q, wb_data_d;
    logic                   rsp_err_q, rsp_err_d;

    logic                   free_found;
    logic [TID_WIDTH-1:0]   free_idx;
    logic                   accept;
    logic                   rsp_match;
    logic                   sel_killed;
    logic [SB_ID_WIDTH-1:0] sel_id;
    logic [OFF_W-1:0]       sel_off;
    logic [1:0]             sel_size;
    logic                   sel_sgn;
    logic [CNT_W-1:0]       count;

    // Descending scan so the lowest free index is the one that sticks.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NR_ENTRIES-1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = TID_WIDTH'(i);
            end
        end
    end

    assign accept = bus.req_valid_i && free_found && !bus.flush_i;

    // Out-of-range TIDs never compare equal to a slot index, so they fall to the error path.
    always_comb begin
        rsp_match  = 1'b0;
        sel_killed = 1'b0;
        sel_id     = '0;
        sel_off    = '0;
        sel_size   = '0;
        sel_sgn    = 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (bus.rsp_valid_i && (bus.rsp_tid_i == TID_WIDTH'(i)) && valid_q[i]) begin
                rsp_match  = 1'b1;
                sel_killed = killed_q[i];
                sel_id     = sb_id_q[i];
                sel_off    = off_q[i];
                sel_size   = size_q[i];
                sel_sgn    = sgn_q[i];
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        killed_d = killed_q;
        sb_id_d  = sb_id_q;
        off_d    = off_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (bus.flush_i && valid_q[i]) killed_d[i] = 1'b1;
            if (bus.rsp_valid_i && (bus.rsp_tid_i == TID_WIDTH'(i)) && valid_q[i]) begin
                valid_d[i]  = 1'b0;
                killed_d[i] = 1'b0;
            end
            if (accept && (free_idx == TID_WIDTH'(i))) begin
                valid_d[i]  = 1'b1;
                killed_d[i] = 1'b0;
                sb_id_d[i]  = bus.req_trans_id_i;
                off_d[i]    = bus.req_offset_i;
                size_d[i]   = bus.req_size_i;
                sgn_d[i]    = bus.req_signed_i;
            end
        end
    end

    // A same-cycle flush squashes the matching response as well.
    always_comb begin
        wb_valid_d    = rsp_match && !sel_killed && !bus.flush_i;
        wb_trans_id_d = wb_trans_id_q;
        wb_data_d     = wb_data_q;
        if (wb_valid_d) begin
            wb_trans_id_d = sel_id;
            wb_data_d     = extend_load(bus.rsp_data_i, sel_off, sel_size, sel_sgn);
        end
        rsp_err_d = bus.rsp_valid_i && !rsp_match;
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NR_ENTRIES; i++) count = count + CNT_W'(valid_q[i]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q       <= '0;
            killed_q      <= '0;
            wb_valid_q    <= 1'b0;
            wb_trans_id_q <= '0;
            wb_data_q     <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            killed_q      <= killed_d;
            wb_valid_q    <= wb_valid_d;
            wb_trans_id_q <= wb_trans_id_d;
            wb_data_q     <= wb_data_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    // Per-slot payload is only meaningful while its valid bit is set.
    always_ff @(posedge clk_i) begin
        sb_id_q <= sb_id_d;
        off_q   <= off_d;
        size_q  <= size_d;
        sgn_q   <= sgn_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (count <= CNT_W'(NR_ENTRIES));
    end

    assign bus.req_ready_o   = free_found && !bus.flush_i;
    assign bus.req_tid_o     = free_idx;
    assign bus.wb_valid_o    = wb_valid_q;
    assign bus.wb_trans_id_o = wb_trans_id_q;
    assign bus.wb_data_o     = wb_data_q;
    assign bus.rsp_err_o     = rsp_err_q;
    assign bus.count_o       = count;
    assign bus.busy_o        = (count != '0);
endmodule

// File: tb/tb_load_tid_tracker.sv
// Bench for load_tid_tracker: directed scenarios then random traffic, all checked
// against a slot-state reference model kept in this file.
module tb_load_tid_tracker;
    localparam int XLEN = 64;
    localparam int NR   = 2;
    localparam int TIDW = 2;
    localparam int SBW  = 3;

    typedef enum int {FREE, PEND, KILLED} slot_e;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    slot_e       m_st   [NR];
    int          m_id   [NR];
    int          m_off  [NR];
    int          m_size [NR];
    bit          m_sgn  [NR];

    load_tid_tracker_if #(.XLEN(XLEN), .NR_ENTRIES(NR), .TID_WIDTH(TIDW), .SB_ID_WIDTH(SBW)) bus ();

    load_tid_tracker #(.XLEN(XLEN), .NR_ENTRIES(NR), .TID_WIDTH(TIDW), .SB_ID_WIDTH(SBW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_ext(input logic [63:0] raw, input int off,
                                              input int size, input bit sgn);
        logic [63:0] v;
        logic [63:0] m;
        int bits;
        v    = raw >> (off * 8);
        bits = 8 << size;
        if (bits >= XLEN) return v;
        m = (64'd1 << bits) - 64'd1;
        v = v & m;
        if (sgn && v[bits-1]) v = v | ~m;
        return v;
    endfunction

    task automatic drive(input bit rv, input int id, input int off, input int size, input bit sgn,
                         input bit pv, input int ptid, input logic [63:0] pdata,
                         input bit fl, input bit r);
        bus.req_valid_i    = rv;
        bus.req_trans_id_i = SBW'(id);
        bus.req_offset_i   = 3'(off);
        bus.req_size_i     = 2'(size);
        bus.req_signed_i   = sgn;
        bus.rsp_valid_i    = pv;
        bus.rsp_tid_i      = TIDW'(ptid);
        bus.rsp_data_i     = pdata;
        bus.flush_i        = fl;
        rst                = r;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 0);
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        bit          exp_ready;
        int          exp_tid;
        bit          exp_wb;
        bit          exp_err;
        int          exp_id;
        logic [63:0] exp_data;
        int          t;
        int          cnt;
        bit          was_rst;
        #1;
        was_rst   = rst;
        exp_ready = 0;
        exp_tid   = 0;
        for (int i = NR-1; i >= 0; i--) if (m_st[i] == FREE) begin exp_ready = 1; exp_tid = i; end
        exp_ready = exp_ready && !bus.flush_i;
        exp_wb   = 0;
        exp_err  = 0;
        exp_id   = 0;
        exp_data = '0;
        if (!was_rst) begin
            chk("req_ready", 64'(bus.req_ready_o), 64'(exp_ready));
            if (exp_ready) chk("req_tid", 64'(bus.req_tid_o), 64'(exp_tid));
            if (bus.rsp_valid_i) begin
                t = int'(bus.rsp_tid_i);
                if (t < NR && m_st[t] != FREE) begin
                    if (m_st[t] == PEND && !bus.flush_i) begin
                        exp_wb   = 1;
                        exp_id   = m_id[t];
                        exp_data = model_ext(bus.rsp_data_i, m_off[t], m_size[t], m_sgn[t]);
                    end
                    m_st[t] = FREE;
                end else begin
                    exp_err = 1;
                end
            end
            if (bus.flush_i) for (int i = 0; i < NR; i++) if (m_st[i] == PEND) m_st[i] = KILLED;
            if (bus.req_valid_i && exp_ready) begin
                m_st[exp_tid]   = PEND;
                m_id[exp_tid]   = int'(bus.req_trans_id_i);
                m_off[exp_tid]  = int'(bus.req_offset_i);
                m_size[exp_tid] = int'(bus.req_size_i);
                m_sgn[exp_tid]  = bus.req_signed_i;
            end
        end else begin
            for (int i = 0; i < NR; i++) m_st[i] = FREE;
        end
        @(posedge clk);
        #1;
        cnt = 0;
        for (int i = 0; i < NR; i++) if (m_st[i] != FREE) cnt++;
        chk("wb_valid", 64'(bus.wb_valid_o), 64'(exp_wb));
        chk("rsp_err", 64'(bus.rsp_err_o), 64'(exp_err));
        chk("count", 64'(bus.count_o), 64'(cnt));
        chk("busy", 64'(bus.busy_o), 64'(cnt != 0));
        if (exp_wb) begin
            chk("wb_trans_id", 64'(bus.wb_trans_id_o), 64'(exp_id));
            chk("wb_data", bus.wb_data_o, exp_data);
        end
        if (was_rst) begin
            chk("rst_wb_trans_id", 64'(bus.wb_trans_id_o), 64'd0);
            chk("rst_wb_data", bus.wb_data_o, 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_st[i] = FREE; m_id[i] = 0; m_off[i] = 0; m_size[i] = 0; m_sgn[i] = 0;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 1);
        step();
        step();
        idle();
        #1;
        chk("ready_after_reset", 64'(bus.req_ready_o), 64'd1);

        // Basic doubleword load
        drive(1, 5, 0, 3, 0, 0, 0, 64'd0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 1, 0, 64'h1122334455667788, 0, 0);
        step();
        chk("basic_wb_valid", 64'(bus.wb_valid_o), 64'd1);
        chk("basic_wb_id", 64'(bus.wb_trans_id_o), 64'd5);
        chk("basic_wb_data", bus.wb_data_o, 64'h1122334455667788);
        idle();
        step();

        // Byte at offset 6, signed then unsigned
        drive(1, 3, 6, 0, 1, 0, 0, 64'd0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 1, 0, 64'h0080_0000_0000_0000, 0, 0);
        step();
        chk("sext_byte", bus.wb_data_o, 64'hFFFF_FFFF_FFFF_FF80);
        drive(1, 3, 6, 0, 0, 0, 0, 64'd0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 1, 0, 64'h0080_0000_0000_0000, 0, 0);
        step();
        chk("zext_byte", bus.wb_data_o, 64'h80);

        // Fill, then out-of-order completion
        drive(1, 1, 0, 3, 0, 0, 0, 64'd0, 0, 0);
        step();
        drive(1, 2, 0, 3, 0, 0, 0, 64'd0, 0, 0);
        step();
        idle();
        step();
        chk("full_count", 64'(bus.count_o), 64'd2);
        chk("full_ready", 64'(bus.req_ready_o), 64'd0);
        drive(0, 0, 0, 0, 0, 1, 1, 64'hA5A5, 0, 0);
        step();
        chk("ooo_first_id", 64'(bus.wb_trans_id_o), 64'd2);
        drive(0, 0, 0, 0, 0, 1, 0, 64'h5A5A, 0, 0);
        step();
        chk("ooo_second_id", 64'(bus.wb_trans_id_o), 64'd1);
        idle();
        #1;
        chk("ooo_ready_again", 64'(bus.req_ready_o), 64'd1);

        // Flush with two loads outstanding; requests held until slots drain
        drive(1, 4, 0, 3, 0, 0, 0, 64'd0, 0, 0);
        step();
        drive(1, 6, 0, 3, 0, 0, 0, 64'd0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 1, 0);
        step();
        drive(1, 7, 0, 3, 0, 1, 0, 64'hDEAD, 0, 0);
        step();
        chk("flush_count1", 64'(bus.count_o), 64'd1);
        drive(1, 7, 0, 3, 0, 1, 1, 64'hBEEF, 0, 0);
        step();
        idle();
        step();
        drive(0, 0, 0, 0, 0, 1, 0, 64'h1234, 0, 0);
        step();
        chk("post_flush_wb", 64'(bus.wb_trans_id_o), 64'd7);

        // Response to an unallocated TID
        drive(0, 0, 0, 0, 0, 1, 1, 64'h9, 0, 0);
        step();
        chk("err_pulse", 64'(bus.rsp_err_o), 64'd1);
        idle();
        step();
        chk("err_cleared", 64'(bus.rsp_err_o), 64'd0);

        // Same-cycle free and request while full
        drive(1, 1, 0, 3, 0, 0, 0, 64'd0, 0, 0);
        step();
        drive(1, 2, 0, 3, 0, 0, 0, 64'd0, 0, 0);
        step();
        drive(1, 3, 0, 3, 0, 1, 0, 64'h77, 0, 0);
        step();
        drive(1, 3, 0, 3, 0, 0, 0, 64'd0, 0, 0);
        #1;
        chk("reuse_tid", 64'(bus.req_tid_o), 64'd0);
        step();

        // Reset mid-operation, late responses flagged
        drive(0, 0, 0, 0, 0, 0, 0, 64'd0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 1, 0, 64'h55, 0, 0);
        step();
        chk("late_rsp_err", 64'(bus.rsp_err_o), 64'd1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 7) < 6) ? $urandom_range(0, 1) : $urandom_range(2, 3),
                  {$urandom, $urandom}, ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 63) == 0));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/load_tid_tracker.md
Name: load_tid_tracker

Overview:
- Parametrised outstanding-load tracker between the load unit and the data-cache/NoC response path.
- Allocates a memory transaction ID (TID) per issued load and records the scoreboard trans-id, byte offset, size and sign for that load.
- Matches out-of-order responses by TID and writes back aligned, extended data with a 1-cycle registered latency.
- Supports flush: in-flight loads are squashed, but their TIDs are held until their responses drain.

Parameters:
- XLEN, 64, data width; 32 or 64.
- NR_ENTRIES, 2, number of outstanding loads; 1..16.
- TID_WIDTH, 2, memory TID width; elaboration error if 2**TID_WIDTH < NR_ENTRIES.
- SB_ID_WIDTH, 3, scoreboard trans-id width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  load issue request
- req_ready_o  out  1  a free entry exists and flush_i is low
- req_trans_id_i  in  SB_ID_WIDTH  scoreboard id
- req_offset_i  in  $clog2(XLEN/8)  byte offset within the word
- req_size_i  in  2  0=B, 1=H, 2=W, 3=D (3 is illegal when XLEN=32)
- req_signed_i  in  1  sign-extend result
- req_tid_o  out  TID_WIDTH  TID allocated to the current request (combinational)
- rsp_valid_i  in  1  memory response
- rsp_tid_i  in  TID_WIDTH  response TID
- rsp_data_i  in  XLEN  raw word
- flush_i  in  1  squash all outstanding loads
- wb_valid_o  out  1  writeback strobe
- wb_trans_id_o  out  SB_ID_WIDTH  scoreboard id of the written-back load
- wb_data_o  out  XLEN  aligned, extended data
- rsp_err_o  out  1  pulse: response to an unallocated TID
- busy_o  out  1  any entry valid
- count_o  out  $clog2(NR_ENTRIES+1)  number of valid entries

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset state: all entry valid/killed bits cleared.
- Reset values of outputs: wb_valid_o=0, wb_trans_id_o=0, wb_data_o=0, rsp_err_o=0, busy_o=0, count_o=0; req_ready_o=1 in the first cycle after reset.
- Reset mid-operation drops all entries; late responses that arrive afterwards raise rsp_err_o.
- Entry state per slot: FREE -> PENDING on accept -> FREE on response. A PENDING slot moves to KILLED on flush_i and returns to FREE on response with no writeback.
- Allocation:
  - A request is accepted when req_valid_i && req_ready_o.
  - The entry chosen is the lowest-index FREE entry; req_tid_o = that index, zero-extended.
  - req_ready_o is computed from registered state only. A slot freed by a response this cycle is reusable next cycle, not the same cycle.
- Response:
  - If rsp_valid_i and entry[rsp_tid_i] is PENDING: next cycle wb_valid_o=1, wb_trans_id_o=stored id, wb_data_o=extend(rsp_data_i >> (offset*8), size, signed). The entry frees at that same edge.
  - Extension: result bits above 8<<size are zero-filled, or filled with the top kept bit when signed. For size=3, or size=2 with XLEN=32, the data passes through unchanged.
  - If the entry is KILLED: the entry frees and wb_valid_o stays 0.
  - If the entry is FREE, or rsp_tid_i >= NR_ENTRIES: rsp_err_o=1 next cycle for one cycle; state is unchanged.
  - wb_valid_o is a single-cycle pulse. There is no backpressure: writeback always accepts.
- Flush:
  - flush_i marks every PENDING entry KILLED at the next edge and forces req_ready_o=0 that cycle.
  - A response arriving in the same cycle as flush_i for the same entry is treated as killed and produces no writeback.
- Simultaneous accept + response on different entries: both take effect.
- count_o = number of PENDING + KILLED entries; busy_o = (count_o != 0).
- Full: with count_o == NR_ENTRIES, req_ready_o=0 and requests hold.
- Assertions: an accept while req_ready_o=0 is a protocol violation; count_o never exceeds NR_ENTRIES.

Test Plan:
- Reset, then req(id=5, off=0, size=3), then rsp(tid=0, data=64'h1122334455667788) -> req_tid_o=0; one cycle after rsp: wb_valid_o=1, wb_trans_id_o=5, wb_data_o=64'h1122334455667788; count_o returns 0.
- Alignment and sign: req(off=6, size=0, signed=1), rsp data=64'h0080_0000_0000_0000 -> wb_data_o=64'hFFFF_FFFF_FFFF_FF80. Same stimulus with signed=0 -> 64'h80.
- Fill and out-of-order (NR_ENTRIES=2): issue ids 1 and 2 -> TIDs 0 and 1; req_ready_o=0 with count_o=2. Then rsp tid=1 -> writeback id 2; rsp tid=0 -> writeback id 1; req_ready_o=1 again.
- Flush: 2 loads outstanding, pulse flush_i, then deliver both responses -> no wb_valid_o; count_o goes 2->1->0; new requests accepted only after the slots are freed.
- Error: rsp(tid=1) with no allocation -> rsp_err_o=1 for exactly one cycle, count_o unchanged, no writeback.
- Same-cycle free and request with both entries full: rsp tid=0 and req_valid_i in the same cycle -> request not accepted that cycle; accepted next cycle with req_tid_o=0.
